// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO stream reader and its skid buffer.
package fifo_stream_pkg;

  localparam int DATA_W     = 8;
  localparam int SKID_DEPTH = 2;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [1:0]        occ_t;

  // Occupancy after one cycle of simultaneous push/pop activity.
  function automatic occ_t occ_next(input occ_t occ, input logic push, input logic pop);
    occ_t nxt;
    nxt = occ;
    if (push && !pop) begin
      nxt = occ + 2'd1;
    end else if (pop && !push) begin
      nxt = occ - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_skid_buf2.sv
// Two-entry circular skid buffer: push at the tail, pop from the head, head is registered data.
module skid_buf2
  import fifo_stream_pkg::*;
#(
  parameter int G_WIDTH = DATA_W
) (
  input  logic               i_clk,
  input  logic               i_arst_n,
  input  logic               i_push,
  input  logic [G_WIDTH-1:0] i_push_data,
  input  logic               i_pop,
  output logic [1:0]         o_occ,
  output logic [G_WIDTH-1:0] o_head
);

  logic [G_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [G_WIDTH-1:0] mem_d [SKID_DEPTH];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  occ_t               occ_q, occ_d;

  // The caller guarantees push only when space exists (after accounting for pop).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_push) begin
      mem_d[wr_ptr_q] = i_push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (i_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_next(occ_q, i_push, i_pop);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign o_occ  = occ_q;
  assign o_head = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side FIFO client re-presenting popped words as a valid/ready stream via a 2-entry skid buffer.
// Optional delivered-word counter o_word_cnt is built when FIFO_STREAM_READER_WORD_CNT_EN is defined.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int G_WIDTH  = DATA_W,
  parameter int G_WCNT_W = 16
) (
  input  logic                i_clk,
  input  logic                i_arst_n,
  input  logic                i_en,
  output logic                o_rd,
  input  logic                i_empty,
  input  logic [G_WIDTH-1:0]  i_data,
  input  logic                i_rd_done,
  output logic                o_valid,
  output logic [G_WIDTH-1:0]  o_data,
  input  logic                i_ready,
  output logic                o_err
`ifdef FIFO_STREAM_READER_WORD_CNT_EN
  ,
  output logic [G_WCNT_W-1:0] o_word_cnt
`endif
);

  if (G_WIDTH < 1) begin : g_bad_width
    $error("G_WIDTH must be positive");
  end
  if (G_WCNT_W < 1) begin : g_bad_wcnt
    $error("G_WCNT_W must be positive");
  end

  logic       pending_q, pending_d;
  logic       err_q, err_d;
  logic [1:0] occ;
  logic [2:0] committed;
  logic       pop, push, orphan, overflow;

  // Stream handshake: a word transfers on a cycle with o_valid && i_ready; once o_valid
  // rises, o_valid and o_data hold until that transfer, independent of i_en.
  assign pop = o_valid && i_ready;

  always_comb begin
    committed = {1'b0, occ} + {2'b00, pending_q} - {2'b00, pop};
    o_rd      = i_en && !i_empty && (committed < 3'(SKID_DEPTH));
    orphan    = i_rd_done && !pending_q;
    overflow  = i_rd_done && pending_q && (occ == 2'(SKID_DEPTH)) && !pop;
    push      = i_rd_done && !orphan && !overflow;
    pending_d = o_rd && !i_empty;
    err_d     = err_q || orphan || overflow;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  skid_buf2 #(
    .G_WIDTH (G_WIDTH)
  ) u_skid (
    .i_clk       (i_clk),
    .i_arst_n    (i_arst_n),
    .i_push      (push),
    .i_push_data (i_data),
    .i_pop       (pop),
    .o_occ       (occ),
    .o_head      (o_data)
  );

  assign o_valid = (occ != 2'd0);
  assign o_err   = err_q;

`ifdef FIFO_STREAM_READER_WORD_CNT_EN
  logic [G_WCNT_W-1:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q + G_WCNT_W'(pop);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign o_word_cnt = word_cnt_q;
`endif

  a_rd_not_empty: assert property (@(posedge i_clk) disable iff (!i_arst_n)
    o_rd |-> !i_empty);

  a_occ_max: assert property (@(posedge i_clk) disable iff (!i_arst_n)
    occ <= 2'(SKID_DEPTH));

  a_hold_stall: assert property (@(posedge i_clk) disable iff (!i_arst_n)
    o_valid && !i_ready |=> $stable(o_data) && o_valid);

  // Orphan strobes are a reported protocol error (o_err), so they are excluded here.
  a_rd_done_follows_rd: assert property (@(posedge i_clk) disable iff (!i_arst_n)
    i_rd_done && !orphan |-> $past(o_rd && !i_empty));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: FIFO model, queue-based reference model, literal pins.
module tb_fifo_stream_reader;

  localparam int W  = 8;
  localparam int CW = 16;

  logic         i_clk = 1'b0;
  logic         i_arst_n = 1'b0;
  logic         i_en = 1'b0;
  logic         o_rd;
  logic         i_empty = 1'b1;
  logic [W-1:0] i_data = '0;
  logic         i_rd_done = 1'b0;
  logic         o_valid;
  logic [W-1:0] o_data;
  logic         i_ready = 1'b0;
  logic         o_err;
`ifdef FIFO_STREAM_READER_WORD_CNT_EN
  logic [CW-1:0] o_word_cnt;
`endif

  fifo_stream_reader #(
    .G_WIDTH  (W),
    .G_WCNT_W (CW)
  ) dut (
    .i_clk      (i_clk),
    .i_arst_n   (i_arst_n),
    .i_en       (i_en),
    .o_rd       (o_rd),
    .i_empty    (i_empty),
    .i_data     (i_data),
    .i_rd_done  (i_rd_done),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .i_ready    (i_ready),
    .o_err      (o_err)
`ifdef FIFO_STREAM_READER_WORD_CNT_EN
    ,
    .o_word_cnt (o_word_cnt)
`endif
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  // FIFO contents, reference buffer contents, and delivery logs
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] src_q[$];
  int           pop_cyc[$];
  logic         fl_fire = 1'b0;
  logic [W-1:0] fl_word = '0;
  logic         m_inflight = 1'b0;
  logic         m_err = 1'b0;
  int           m_cnt = 0;
  int           cyc = 0;
  int           rd_cnt = 0;
  int           pass_cnt = 0;
  int           chk_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic clear_logs();
    got_q.delete();
    pop_cyc.delete();
    rd_cnt = 0;
  endtask

  // One clock cycle: drive at negedge, compare against the model, then advance model and FIFO.
  task automatic step(input logic en, input logic rdy,
                      input logic inject = 1'b0, input logic [W-1:0] inj_word = '0);
    logic m_pop, m_rd;
    int   m_occ;
    @(negedge i_clk);
    i_en      = en;
    i_ready   = rdy;
    i_empty   = (fifo_q.size() == 0);
    i_rd_done = fl_fire | inject;
    i_data    = fl_fire ? fl_word : inj_word;
    #1;
    m_occ = exp_q.size();
    m_pop = (m_occ != 0) && rdy;
    m_rd  = en && !i_empty && ((m_occ + int'(m_inflight) - int'(m_pop)) < 2);
    chk("o_valid", 32'(o_valid), 32'(m_occ != 0));
    if (m_occ != 0) chk("o_data", 32'(o_data), 32'(exp_q[0]));
    chk("o_rd", 32'(o_rd), 32'(m_rd));
    chk("rd_while_empty", 32'(o_rd & i_empty), 32'(0));
    chk("o_err", 32'(o_err), 32'(m_err));
`ifdef FIFO_STREAM_READER_WORD_CNT_EN
    chk("o_word_cnt", 32'(o_word_cnt), 32'(CW'(m_cnt)));
`endif
    if (o_valid && rdy) begin
      got_q.push_back(o_data);
      pop_cyc.push_back(cyc);
    end
    if (o_rd) rd_cnt++;
    if (m_pop) begin
      void'(exp_q.pop_front());
      m_cnt++;
    end
    if (i_rd_done) begin
      if (!m_inflight) m_err = 1'b1;
      else if (exp_q.size() >= 2) m_err = 1'b1;
      else exp_q.push_back(i_data);
    end
    m_inflight = m_rd;
    fl_fire = o_rd && !i_empty;
    if (fl_fire) fl_word = fifo_q.pop_front();
    cyc++;
  endtask

  task automatic async_reset();
    @(negedge i_clk);
    i_en      = 1'b0;
    i_ready   = 1'b0;
    i_rd_done = 1'b0;
    #2 i_arst_n = 1'b0;
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'(0));
    chk("rst_o_err", 32'(o_err), 32'(0));
    chk("rst_o_data", 32'(o_data), 32'(0));
    chk("rst_o_rd", 32'(o_rd), 32'(0));
`ifdef FIFO_STREAM_READER_WORD_CNT_EN
    chk("rst_word_cnt", 32'(o_word_cnt), 32'(0));
`endif
    exp_q.delete();
    m_inflight = 1'b0;
    m_err      = 1'b0;
    m_cnt      = 0;
    fl_fire    = 1'b0;
    @(negedge i_clk);
    i_arst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] t1_w [4];
    int           budget;
    int           order_errs;
    t1_w = '{8'h11, 8'h22, 8'h33, 8'h44};

    async_reset();

    // Streaming at full rate
    clear_logs();
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (8) step(1'b1, 1'b1);
    chk("t1_rd_cnt", 32'(rd_cnt), 32'(4));
    chk("t1_pops", 32'(got_q.size()), 32'(4));
    for (int i = 0; i < 4; i++) if (i < got_q.size()) chk("t1_word", 32'(got_q[i]), 32'(t1_w[i]));
    if (pop_cyc.size() == 4) chk("t1_back_to_back", 32'(pop_cyc[3] - pop_cyc[0]), 32'(3));

    // Consumer stalled: buffer fills with two words, then drains in order
    clear_logs();
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (6) step(1'b1, 1'b0);
    chk("t2_rd_cnt", 32'(rd_cnt), 32'(2));
    chk("t2_head", 32'(o_data), 32'(8'h11));
    chk("t2_rd_idle", 32'(o_rd), 32'(0));
    chk("t2_valid", 32'(o_valid), 32'(1));
    repeat (8) step(1'b1, 1'b1);
    chk("t2_pops", 32'(got_q.size()), 32'(4));
    for (int i = 0; i < 4; i++) if (i < got_q.size()) chk("t2_word", 32'(got_q[i]), 32'(t1_w[i]));

    // Enable dropped the cycle after a read was issued
    clear_logs();
    fifo_q = '{8'hA1, 8'hA2, 8'hA3};
    step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    chk("t4_rd_cnt", 32'(rd_cnt), 32'(1));
    chk("t4_pops", 32'(got_q.size()), 32'(1));
    if (got_q.size() > 0) chk("t4_word", 32'(got_q[0]), 32'(8'hA1));
    chk("t4_valid_low", 32'(o_valid), 32'(0));

    // Orphan read-done strobe while the buffer is full
    clear_logs();
    repeat (4) step(1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hEE);
    step(1'b0, 1'b0);
    chk("t5_err", 32'(o_err), 32'(1));
    chk("t5_head", 32'(o_data), 32'(8'hA2));
    repeat (4) step(1'b0, 1'b1);
    chk("t5_pops", 32'(got_q.size()), 32'(2));
    if (got_q.size() == 2) begin
      chk("t5_word0", 32'(got_q[0]), 32'(8'hA2));
      chk("t5_word1", 32'(got_q[1]), 32'(8'hA3));
    end
    chk("t5_err_held", 32'(o_err), 32'(1));

    // Reset with one word buffered and one in flight
    clear_logs();
    fifo_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    repeat (2) step(1'b1, 1'b0);
    async_reset();
    repeat (8) step(1'b1, 1'b1);
    chk("t6_pops", 32'(got_q.size()), 32'(2));
    if (got_q.size() > 0) chk("t6_first", 32'(got_q[0]), 32'(8'hB3));

    // Random consumer stalls over 256 random words
    async_reset();
    clear_logs();
    src_q.delete();
    for (int i = 0; i < 256; i++) begin
      src_q.push_back(W'($urandom_range(0, 255)));
      fifo_q.push_back(src_q[i]);
    end
    budget = 0;
    while (got_q.size() < 256 && budget < 3000) begin
      step(1'b1, 1'($urandom_range(0, 1)));
      budget++;
    end
    chk("t3_delivered", 32'(got_q.size()), 32'(256));
    order_errs = 0;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== src_q[i]) order_errs++;
    chk("t3_order_errs", 32'(order_errs), 32'(0));
    step(1'b1, 1'b0);
`ifdef FIFO_STREAM_READER_WORD_CNT_EN
    chk("t3_word_cnt", 32'(o_word_cnt), 32'(256));
`endif
    chk("t3_err", 32'(o_err), 32'(0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
